// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IMEM request/response, ID-stage head and hazard control bundle for fetch_queue
interface fetch_queue_if #(
  parameter int CNT_W = 5
);
  logic [3:0] hazard_signal;
  logic id_stall;
  logic fence_active;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic imem_fault;
  logic id_valid;
  logic [31:0] id_pc;
  logic [31:0] instruction;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic id_fetch_fault;
  logic [CNT_W-1:0] occupancy;
  modport master (
    input hazard_signal, id_stall, fence_active, redirect_valid, redirect_pc,
    input imem_ready, imem_rsp_valid, imem_rsp_data, imem_fault,
    output imem_req, imem_addr, id_valid, id_pc, instruction, rs1, rs2, rd, id_fetch_fault, occupancy
  );
  modport slave (
    output hazard_signal, id_stall, fence_active, redirect_valid, redirect_pc,
    output imem_ready, imem_rsp_valid, imem_rsp_data, imem_fault,
    input imem_req, imem_addr, id_valid, id_pc, instruction, rs1, rs2, rd, id_fetch_fault, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order IMEM fetch into an instruction FIFO feeding decode; FETCH_QUEUE_BYPASS_EN adds a same-cycle response bypass
`ifndef FLUSH_EARLY
`define FLUSH_EARLY 4'h1
`endif
`ifndef FLUSH_ALL
`define FLUSH_ALL 4'h2
`endif
`ifndef STALL_MMU
`define STALL_MMU 4'h3
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic q_fault [DEPTH];
  logic [31:0] ip_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, ip_rd, ip_wr;
  logic [CNT_W-1:0] count, inflight, drop;
  logic [31:0] fetch_pc;
  logic fault_lock;
  logic flush, issue, rsp_take, bypass, advance, push, pop, valid, head_fault;
  logic [31:0] head_pc, head_data, inst;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = rsp_take && count == '0;
`else
  assign bypass = 1'b0;
`endif
  // issue, response acceptance and head selection
  always_comb begin
    flush = bus.hazard_signal == `FLUSH_EARLY || bus.hazard_signal == `FLUSH_ALL || bus.redirect_valid;
    bus.imem_req = !rst && !fault_lock && !flush && (count + inflight) < CNT_W'(DEPTH);
    bus.imem_addr = fetch_pc;
    issue = bus.imem_req && bus.imem_ready;
    rsp_take = bus.imem_rsp_valid && drop == '0 && !flush;
    valid = count != '0 || bypass;
    head_pc = bypass ? ip_pc[ip_rd] : q_pc[rd_ptr];
    head_data = bypass ? bus.imem_rsp_data : q_data[rd_ptr];
    head_fault = bypass ? bus.imem_fault : q_fault[rd_ptr];
    advance = valid && !bus.id_stall && !bus.fence_active && bus.hazard_signal != `STALL_MMU;
    push = rsp_take && !(bypass && advance);
    pop = advance && !flush && !bypass;
    inst = valid ? head_data : `INST_NOP;
    bus.id_valid = valid;
    bus.id_pc = valid ? head_pc : 32'h0;
    bus.instruction = inst;
    bus.rs1 = inst[19:15];
    bus.rs2 = inst[24:20];
    bus.rd = inst[11:7];
    bus.id_fetch_fault = valid && head_fault;
    bus.occupancy = count;
  end
  // control state: pointers, counters, drop accounting, fault lock and fetch PC
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count <= '0;
      inflight <= '0;
      drop <= '0;
      fault_lock <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      ip_rd <= '0;
      ip_wr <= '0;
    end else begin
      inflight <= inflight + CNT_W'(issue) - CNT_W'(bus.imem_rsp_valid);
      ip_wr <= ip_wr + AW'(issue);
      ip_rd <= ip_rd + AW'(bus.imem_rsp_valid);
      drop <= flush ? inflight - CNT_W'(bus.imem_rsp_valid) : drop - CNT_W'(bus.imem_rsp_valid && drop != '0);
      fault_lock <= flush ? 1'b0 : fault_lock || (rsp_take && bus.imem_fault);
      count <= flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      fetch_pc <= bus.redirect_valid ? (bus.redirect_pc & ~32'h3) : issue ? fetch_pc + 32'd4 : fetch_pc;
    end
  end
  // entry and issue-PC storage; contents are meaningful only under the valid counts
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr] <= ip_pc[ip_rd];
      q_data[wr_ptr] <= bus.imem_rsp_data;
      q_fault[wr_ptr] <= bus.imem_fault;
    end
    if (issue) ip_pc[ip_wr] <= fetch_pc;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with an in-order IMEM responder
`ifndef FLUSH_EARLY
`define FLUSH_EARLY 4'h1
`endif
`ifndef FLUSH_ALL
`define FLUSH_ALL 4'h2
`endif
`ifndef STALL_MMU
`define STALL_MMU 4'h3
`endif
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  logic rsp_en;
  logic fault_en;
  logic [31:0] fault_addr;
  logic [31:0] pend [$];
  fetch_queue_if #(.CNT_W(5)) bus ();
  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'h00B5_0533 | {a[8:2], 25'd0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic acc;
    logic [31:0] aa;
    if (rsp_en && pend.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = data_of(pend[0]);
      bus.imem_fault = fault_en && pend[0] == fault_addr;
    end
    #1;
    acc = bus.imem_req && bus.imem_ready;
    aa = bus.imem_addr;
    @(posedge clk);
    if (bus.imem_rsp_valid) void'(pend.pop_front());
    if (acc) pend.push_back(aa);
    if (rst) pend.delete();
    #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_fault = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    rsp_en = 1'b1;
    fault_en = 1'b0;
    fault_addr = 32'h0;
    bus.hazard_signal = 4'h0;
    bus.id_stall = 1'b0;
    bus.fence_active = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.imem_fault = 1'b0;
    cyc();
    cyc();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.id_valid, 0);
    chk("rst_inst", bus.instruction, 32'h13);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_fault", bus.id_fetch_fault, 0);
    rst = 1'b0;
    #1;
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    bus.imem_ready = 1'b1;
    cyc();
    chk("addr_4", bus.imem_addr, 32'h4);
    chk("valid_lat", bus.id_valid, 0);
    cyc();
    chk("valid_on", bus.id_valid, 1);
    chk("pc_0", bus.id_pc, 32'h0);
    chk("inst_0", bus.instruction, data_of(32'h0));
    chk("addr_8", bus.imem_addr, 32'h8);
    cyc();
    chk("pc_4", bus.id_pc, 32'h4);
    cyc();
    chk("pc_8", bus.id_pc, 32'h8);
    bus.id_stall = 1'b1;
    cyc();
    chk("stall_hold0", bus.id_pc, 32'h8);
    for (int i = 0; i < 9; i++) cyc();
    chk("stall_occ", bus.occupancy, 4);
    chk("stall_req", bus.imem_req, 0);
    chk("stall_pc", bus.id_pc, 32'h8);
    chk("stall_inst", bus.instruction, data_of(32'h8));
    bus.id_stall = 1'b0;
    cyc();
    chk("rel_pc_c", bus.id_pc, 32'hC);
    cyc();
    chk("rel_pc_10", bus.id_pc, 32'h10);
    cyc();
    chk("rel_pc_14", bus.id_pc, 32'h14);
    cyc();
    chk("rel_pc_18", bus.id_pc, 32'h18);
    rst = 1'b1;
    bus.id_stall = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    cyc();
    rsp_en = 1'b0;
    cyc();
    chk("pre_redir_occ", bus.occupancy, 2);
    chk("pre_redir_req", bus.imem_req, 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1002;
    #1;
    chk("flush_req", bus.imem_req, 0);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("redir_occ", bus.occupancy, 0);
    chk("redir_valid", bus.id_valid, 0);
    chk("redir_req", bus.imem_req, 1);
    chk("redir_addr", bus.imem_addr, 32'h1000);
    rsp_en = 1'b1;
    cyc();
    chk("drop1_occ", bus.occupancy, 0);
    cyc();
    chk("drop2_occ", bus.occupancy, 0);
    chk("drop2_valid", bus.id_valid, 0);
    cyc();
    chk("redir_head_valid", bus.id_valid, 1);
    chk("redir_head_pc", bus.id_pc, 32'h1000);
    chk("redir_head_inst", bus.instruction, data_of(32'h1000));
    chk("redir_head_occ", bus.occupancy, 1);
    rst = 1'b1;
    bus.id_stall = 1'b0;
    fault_en = 1'b1;
    fault_addr = 32'h8;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    cyc();
    bus.imem_ready = 1'b0;
    cyc();
    chk("fault_pc", bus.id_pc, 32'h8);
    chk("fault_flag", bus.id_fetch_fault, 1);
    chk("fault_lock_req", bus.imem_req, 0);
    bus.id_stall = 1'b1;
    bus.imem_ready = 1'b1;
    cyc();
    chk("fault_lock_req2", bus.imem_req, 0);
    chk("fault_hold", bus.id_fetch_fault, 1);
    bus.hazard_signal = `FLUSH_ALL;
    cyc();
    bus.hazard_signal = 4'h0;
    fault_en = 1'b0;
    #1;
    chk("fflush_occ", bus.occupancy, 0);
    chk("fflush_valid", bus.id_valid, 0);
    chk("fflush_fault", bus.id_fetch_fault, 0);
    chk("fflush_req", bus.imem_req, 1);
    chk("fflush_addr", bus.imem_addr, 32'hC);
    bus.id_stall = 1'b0;
    bus.fence_active = 1'b1;
    cyc();
    cyc();
    chk("fence_pc0", bus.id_pc, 32'hC);
    for (int i = 0; i < 6; i++) cyc();
    chk("fence_pc", bus.id_pc, 32'hC);
    chk("fence_occ", bus.occupancy, 4);
    chk("fence_inst", bus.instruction, data_of(32'hC));
    chk("fence_rs1", bus.rs1, 10);
    chk("fence_rs2", bus.rs2, 11);
    chk("fence_rd", bus.rd, 10);
    chk("fence_req", bus.imem_req, 0);
    bus.fence_active = 1'b0;
    bus.hazard_signal = `STALL_MMU;
    cyc();
    cyc();
    chk("mmu_pc", bus.id_pc, 32'hC);
    chk("mmu_occ", bus.occupancy, 4);
    bus.hazard_signal = 4'h0;
    cyc();
    chk("mmu_rel_pc", bus.id_pc, 32'h10);
    chk("mmu_rel_occ", bus.occupancy, 3);
    bus.id_stall = 1'b1;
    cyc();
    cyc();
    chk("full_occ", bus.occupancy, 4);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", bus.id_valid, 0);
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    chk("mid_rst_occ", bus.occupancy, 0);
    chk("mid_rst_inst", bus.instruction, 32'h13);
    rst = 1'b0;
    #1;
    chk("post_rst_req", bus.imem_req, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
